// File: rtl/unpool_stream.sv
// Streaming 2x2 nearest-neighbour unpooling: one pooled row is captured into a
// line buffer, then replayed twice with each value doubled horizontally.
module unpool_stream #(
    parameter int N = 28,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_row_last,
    output logic         out_last
);
    // state | meaning
    // FILL  | accepting M pooled values into line_buf
    // EMIT0 | first replay of line_buf (upper output row of each 2x2 window)
    // EMIT1 | second replay of line_buf (lower output row)

    localparam int M  = N / 2;
    localparam int MW = (M > 1) ? $clog2(M) : 1;
    // out_col carries one extra bit so out_col[CW-1:1] indexes line_buf directly
    localparam int CW = MW + 1;
    localparam logic [MW-1:0] M_LAST = MW'(M - 1);
    localparam logic [CW-1:0] N_LAST = CW'(N - 1);

    if ((N < 2) || ((N % 2) != 0)) begin : g_bad_n
        $error("unpool_stream: N must be even and >= 2");
    end

    typedef enum logic [1:0] {FILL, EMIT0, EMIT1} state_t;

    state_t        state;
    logic [W-1:0]  line_buf [M];
    logic [MW-1:0] in_col;
    logic [MW-1:0] prow;
    logic [CW-1:0] out_col;

    assign in_ready     = (state == FILL);
    assign out_valid    = (state != FILL);
    assign out_data     = out_valid ? line_buf[out_col[CW-1:1]] : '0;
    assign out_row_last = out_valid && (out_col == N_LAST);
    assign out_last     = (state == EMIT1) && (out_col == N_LAST) && (prow == M_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FILL;
            in_col  <= '0;
            out_col <= '0;
            prow    <= '0;
            for (int i = 0; i < M; i++) begin
                line_buf[i] <= '0;
            end
        end else begin
            case (state)
                FILL: begin
                    if (in_valid) begin
                        line_buf[in_col] <= in_data;
                        if (in_col == M_LAST) begin
                            in_col <= '0;
                            state  <= EMIT0;
                        end else begin
                            in_col <= in_col + 1'b1;
                        end
                    end
                end
                EMIT0, EMIT1: begin
                    if (out_ready) begin
                        if (out_col == N_LAST) begin
                            out_col <= '0;
                            if (state == EMIT0) begin
                                state <= EMIT1;
                            end else begin
                                state <= FILL;
                                prow  <= (prow == M_LAST) ? '0 : prow + 1'b1;
                            end
                        end else begin
                            out_col <= out_col + 1'b1;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_unpool_stream.sv
// Directed bench for unpool_stream: N=4 instance for most scenarios,
// N=2 for the degenerate case and N=28 for two back-to-back random images.
module tb_unpool_stream;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;

    logic        iv4, ir4, ov4, or4, orl4, ol4;
    logic [15:0] id4, od4;
    logic        iv2, ir2, ov2, or2, orl2, ol2;
    logic [15:0] id2, od2;
    logic        iv28, ir28, ov28, or28, orl28, ol28;
    logic [15:0] id28, od28;

    unpool_stream #(.N(4), .W(16)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_data(id4),
        .out_valid(ov4), .out_ready(or4), .out_data(od4),
        .out_row_last(orl4), .out_last(ol4));

    unpool_stream #(.N(2), .W(16)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2),
        .out_row_last(orl2), .out_last(ol2));

    unpool_stream #(.N(28), .W(16)) dut28 (
        .clk(clk), .rst(rst), .in_valid(iv28), .in_ready(ir28), .in_data(id28),
        .out_valid(ov28), .out_ready(or28), .out_data(od28),
        .out_row_last(orl28), .out_last(ol28));

    typedef logic [15:0] img4_t [4];

    logic [15:0] cap_d  [16];
    logic        cap_rl [16];
    logic        cap_l  [16];
    int ncap, stall_err, excl_err, tmo;

    // expected N=4 pixel k: output row k/4 uses pooled row k/8, column (k%4)/2
    function automatic logic [15:0] exp4(input img4_t v, input int k);
        return v[(k / 8) * 2 + (k % 4) / 2];
    endfunction

    task automatic push4(input logic [15:0] d, input int gap);
        int t;
        @(negedge clk);
        repeat (gap) @(negedge clk);
        iv4 = 1'b1;
        id4 = d;
        t = 0;
        while (ir4 !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (ir4 !== 1'b1) tmo++;
        @(posedge clk);
        #1 iv4 = 1'b0;
    endtask

    task automatic pop4(input int count, input bit rnd);
        int got, t;
        logic [15:0] pd;
        logic prl, pl;
        bit pst;
        got = 0; t = 0; pst = 0; pd = '0; prl = 0; pl = 0;
        while (got < count && t < 400) begin
            @(negedge clk);
            t++;
            if (pst && (ov4 !== 1'b1 || od4 !== pd || orl4 !== prl || ol4 !== pl)) stall_err++;
            if (ov4 === 1'b1 && ir4 === 1'b1) excl_err++;
            or4 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ov4 === 1'b1 && or4) begin
                if (ncap < 16) begin
                    cap_d[ncap]  = od4;
                    cap_rl[ncap] = orl4;
                    cap_l[ncap]  = ol4;
                end
                ncap++;
                got++;
            end
            pst = (ov4 === 1'b1) && !or4;
            pd = od4; prl = orl4; pl = ol4;
        end
        if (got < count) tmo++;
        @(posedge clk);
        #1 or4 = 1'b0;
    endtask

    task automatic run_image4(input img4_t v, input bit rnd);
        ncap = 0;
        push4(v[0], 0);
        push4(v[1], 0);
        pop4(8, rnd);
        push4(v[2], 0);
        push4(v[3], 0);
        pop4(8, rnd);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        ntests++; if (ir4 !== 1'b1) begin nfail++; $display("FAIL reset_in_ready: got %b want 1", ir4); end
        ntests++; if (ov4 !== 1'b0) begin nfail++; $display("FAIL reset_out_valid: got %b want 0", ov4); end
        ntests++; if (orl4 !== 1'b0) begin nfail++; $display("FAIL reset_row_last: got %b want 0", orl4); end
        ntests++; if (ol4 !== 1'b0) begin nfail++; $display("FAIL reset_last: got %b want 0", ol4); end
        ntests++; if (od4 !== 16'h0) begin nfail++; $display("FAIL reset_out_data: got %h want 0000", od4); end
        ntests++; if (ir28 !== 1'b1) begin nfail++; $display("FAIL reset_in_ready28: got %b want 1", ir28); end
        ntests++; if (ov2 !== 1'b0) begin nfail++; $display("FAIL reset_out_valid2: got %b want 0", ov2); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_image4(input string name, input img4_t v);
        ntests++; if (ncap !== 16) begin nfail++; $display("FAIL %s_count: got %0d want 16", name, ncap); end
        for (int k = 0; k < 16 && k < ncap; k++) begin
            ntests++;
            if (cap_d[k] !== exp4(v, k)) begin
                nfail++; $display("FAIL %s_data[%0d]: got %h want %h", name, k, cap_d[k], exp4(v, k));
            end
            ntests++;
            if (cap_rl[k] !== ((k % 4) == 3) || cap_l[k] !== (k == 15)) begin
                nfail++; $display("FAIL %s_flags[%0d]: got rl=%b last=%b want rl=%b last=%b",
                                  name, k, cap_rl[k], cap_l[k], (k % 4) == 3, k == 15);
            end
        end
    endtask

    task automatic test_basic();
        img4_t v;
        v = '{16'd1, 16'd2, 16'd3, 16'd4};
        tmo = 0; excl_err = 0;
        run_image4(v, 1'b0);
        check_image4("basic", v);
        ntests++; if (cap_d[5] !== 16'd1 || cap_d[14] !== 16'd4) begin
            nfail++; $display("FAIL basic_hand: got %0d,%0d want 1,4", cap_d[5], cap_d[14]);
        end
        ntests++; if (excl_err !== 0) begin nfail++; $display("FAIL basic_in_ready_during_emit: got %0d cycles want 0", excl_err); end
        ntests++; if (tmo !== 0) begin nfail++; $display("FAIL basic_timeout: got %0d want 0", tmo); end
    endtask

    task automatic test_signed();
        img4_t v;
        v = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000};
        tmo = 0;
        run_image4(v, 1'b0);
        check_image4("signed", v);
        ntests++; if (cap_d[0] !== 16'h8000 || cap_d[3] !== 16'h7FFF || cap_d[8] !== 16'hFFFF || cap_d[15] !== 16'h0000) begin
            nfail++; $display("FAIL signed_hand: got %h %h %h %h want 8000 7fff ffff 0000", cap_d[0], cap_d[3], cap_d[8], cap_d[15]);
        end
    endtask

    task automatic test_backpressure();
        img4_t v;
        v = '{16'd1, 16'd2, 16'd3, 16'd4};
        tmo = 0; stall_err = 0;
        run_image4(v, 1'b1);
        check_image4("bp", v);
        ntests++; if (stall_err !== 0) begin nfail++; $display("FAIL bp_stable: got %0d unstable cycles want 0", stall_err); end
        ntests++; if (tmo !== 0) begin nfail++; $display("FAIL bp_timeout: got %0d want 0", tmo); end
    endtask

    task automatic test_gaps();
        img4_t v;
        v = '{16'd11, 16'd22, 16'd33, 16'd44};
        tmo = 0; ncap = 0;
        push4(v[0], 1);
        @(negedge clk);
        ntests++; if (ov4 !== 1'b0) begin nfail++; $display("FAIL gaps_early_valid: got %b want 0", ov4); end
        push4(v[1], 1);
        @(negedge clk);
        ntests++; if (ov4 !== 1'b1 || od4 !== 16'd11) begin
            nfail++; $display("FAIL gaps_latency: got valid=%b data=%0d want valid=1 data=11", ov4, od4);
        end
        pop4(8, 1'b0);
        push4(v[2], 1);
        push4(v[3], 1);
        pop4(8, 1'b0);
        check_image4("gaps", v);
    endtask

    task automatic test_reset_mid();
        img4_t v;
        tmo = 0; ncap = 0;
        push4(16'd10, 0);
        push4(16'd20, 0);
        pop4(5, 1'b0);
        @(negedge clk);
        ntests++; if (ov4 !== 1'b1) begin nfail++; $display("FAIL rmid_pre_valid: got %b want 1", ov4); end
        #2 rst = 1'b1;
        #1;
        ntests++; if (ov4 !== 1'b0 || ir4 !== 1'b1 || od4 !== 16'h0) begin
            nfail++; $display("FAIL rmid_async: got valid=%b ready=%b data=%h want 0 1 0000", ov4, ir4, od4);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        ntests++; if (ir4 !== 1'b1) begin nfail++; $display("FAIL rmid_ready_after: got %b want 1", ir4); end
        v = '{16'd5, 16'd6, 16'd7, 16'd8};
        run_image4(v, 1'b0);
        check_image4("rmid", v);
    endtask

    task automatic test_n2();
        int t, got;
        logic [15:0] d [4];
        logic rl [4];
        logic l [4];
        @(negedge clk);
        iv2 = 1'b1; id2 = 16'hABCD; t = 0;
        while (ir2 !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        @(posedge clk);
        #1 iv2 = 1'b0;
        or2 = 1'b1; got = 0; t = 0;
        while (got < 4 && t < 50) begin
            @(negedge clk);
            t++;
            if (ov2 === 1'b1) begin
                d[got] = od2; rl[got] = orl2; l[got] = ol2;
                got++;
            end
        end
        @(posedge clk);
        #1 or2 = 1'b0;
        ntests++; if (got !== 4) begin nfail++; $display("FAIL n2_count: got %0d want 4", got); end
        for (int k = 0; k < 4 && k < got; k++) begin
            ntests++;
            if (d[k] !== 16'hABCD || rl[k] !== ((k % 2) == 1) || l[k] !== (k == 3)) begin
                nfail++; $display("FAIL n2_pix[%0d]: got %h rl=%b last=%b want abcd rl=%b last=%b",
                                  k, d[k], rl[k], l[k], (k % 2) == 1, k == 3);
            end
        end
        @(negedge clk);
        ntests++; if (ir2 !== 1'b1) begin nfail++; $display("FAIL n2_refill: got %b want 1", ir2); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] pool [392];
        int in_idx, out_idx, t, k, img, r, c, derr, ferr, fill_err;
        int lastc [2];
        bit chk_fill;
        for (int i = 0; i < 392; i++) pool[i] = 16'($urandom);
        in_idx = 0; out_idx = 0; t = 0; derr = 0; ferr = 0; fill_err = 0;
        lastc[0] = 0; lastc[1] = 0; chk_fill = 0;
        or28 = 1'b1;
        while (t < 6000 && (out_idx < 1568 || chk_fill)) begin
            @(negedge clk);
            t++;
            if (chk_fill) begin
                chk_fill = 0;
                if (ir28 !== 1'b1 || ov28 !== 1'b0) fill_err++;
            end
            iv28 = (in_idx < 392);
            id28 = iv28 ? pool[in_idx] : 16'h0;
            if (iv28 && ir28 === 1'b1) in_idx++;
            if (ov28 === 1'b1 && out_idx < 1568) begin
                k = out_idx % 784; img = out_idx / 784; r = k / 28; c = k % 28;
                if (od28 !== pool[img * 196 + (r / 2) * 14 + c / 2]) begin
                    if (derr < 4) $display("FAIL b2b_data[%0d]: got %h want %h", out_idx, od28,
                                           pool[img * 196 + (r / 2) * 14 + c / 2]);
                    derr++;
                end
                if (orl28 !== (c == 27)) ferr++;
                if (ol28 === 1'b1) begin
                    lastc[img]++;
                    chk_fill = 1;
                    if (k != 783) ferr++;
                end else if (k == 783) ferr++;
                out_idx++;
            end
        end
        iv28 = 1'b0;
        @(posedge clk);
        #1 or28 = 1'b0;
        ntests++; if (out_idx !== 1568) begin nfail++; $display("FAIL b2b_count: got %0d want 1568", out_idx); end
        ntests++; if (derr !== 0) begin nfail++; $display("FAIL b2b_data_errors: got %0d want 0", derr); end
        ntests++; if (ferr !== 0) begin nfail++; $display("FAIL b2b_flag_errors: got %0d want 0", ferr); end
        ntests++; if (lastc[0] !== 1 || lastc[1] !== 1) begin
            nfail++; $display("FAIL b2b_last_count: got %0d,%0d want 1,1", lastc[0], lastc[1]);
        end
        ntests++; if (fill_err !== 0) begin nfail++; $display("FAIL b2b_fill_after_last: got %0d errors want 0", fill_err); end
    endtask

    initial begin
        rst = 1'b1;
        iv4 = 0; id4 = '0; or4 = 0;
        iv2 = 0; id2 = '0; or2 = 0;
        iv28 = 0; id28 = '0; or28 = 0;
        ncap = 0; stall_err = 0; excl_err = 0; tmo = 0;
        test_reset();
        test_basic();
        test_signed();
        test_backpressure();
        test_gaps();
        test_reset_mid();
        test_n2();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
